// File: rtl/lcd_time_display.sv
// HD44780 4-bit LCD driver: power-on init, then renders "HH:MM:SS" on line 1
// whenever the sampled watch time changes.
module lcd_time_display #(
  parameter int T_PWRON = 750000,
  parameter int T_INIT1 = 205000,
  parameter int T_INIT2 = 5000,
  parameter int T_CMD   = 2000,
  parameter int T_CLEAR = 82000,
  parameter int E_HIGH  = 12,
  parameter int NIB_GAP = 50
) (
  input  logic       CLK,
  input  logic       BTN_SOUTH,
  input  logic [5:0] sec_digits,
  input  logic [5:0] min_digits,
  input  logic [4:0] hrs_digits,
  output logic [3:0] SF_D,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       SF_CE0,
  output logic       ready
);

  localparam int CW = 20;

  typedef enum logic [2:0] {
    PWR_WAIT, SETUP, E_HI, GAP, WAIT, IDLE, SNAP
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    step_q;
  logic          lo_q;
  logic          force_q;
  logic          ready_q;
  logic          e_q;
  logic          rs_q;
  logic [3:0]    d_q;
  logic [4:0]    hrs_q;
  logic [5:0]    min_q;
  logic [5:0]    sec_q;

  logic [7:0]    cur_b_d;
  logic [7:0]    nxt_b_d;
  logic [CW-1:0] wait_end_d;

  function automatic logic [7:0] ascii(
    input logic [5:0] v,
    input logic       tens
  );
    logic [5:0] q;
    q = tens ? v / 6'd10 : v % 6'd10;
    return 8'h30 + {2'b00, q};
  endfunction

  // Steps 0-3 init nibbles, 4-7 init bytes, 8 address, 9-16 text.
  function automatic logic [7:0] byte_at(
    input logic [4:0] s,
    input logic [4:0] h,
    input logic [5:0] m,
    input logic [5:0] sc
  );
    logic [7:0] b;
    b = 8'h00;
    unique case (s)
      5'd0, 5'd1, 5'd2: b = 8'h03;
      5'd3:  b = 8'h02;
      5'd4:  b = 8'h28;
      5'd5:  b = 8'h06;
      5'd6:  b = 8'h0C;
      5'd7:  b = 8'h01;
      5'd8:  b = 8'h80;
      5'd9:  b = ascii({1'b0, h}, 1'b1);
      5'd10: b = ascii({1'b0, h}, 1'b0);
      5'd11: b = 8'h3A;
      5'd12: b = ascii(m, 1'b1);
      5'd13: b = ascii(m, 1'b0);
      5'd14: b = 8'h3A;
      5'd15: b = ascii(sc, 1'b1);
      5'd16: b = ascii(sc, 1'b0);
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_comb begin
    cur_b_d    = byte_at(step_q, hrs_q, min_q, sec_q);
    nxt_b_d    = byte_at(step_q + 5'd1, hrs_q, min_q, sec_q);
    wait_end_d = CW'(T_CMD - 1);
    if (step_q == 5'd0)
      wait_end_d = CW'(T_INIT1 - 1);
    else if (step_q == 5'd1)
      wait_end_d = CW'(T_INIT2 - 1);
    else if (step_q >= 5'd4 && cur_b_d == 8'h01)
      wait_end_d = CW'(T_CLEAR - 1);
  end

  always_ff @(posedge CLK or posedge BTN_SOUTH) begin
    if (BTN_SOUTH) begin
      state_q <= PWR_WAIT;
      cnt_q   <= '0;
      step_q  <= '0;
      lo_q    <= 1'b0;
      force_q <= 1'b0;
      ready_q <= 1'b0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      d_q     <= '0;
      hrs_q   <= '0;
      min_q   <= '0;
      sec_q   <= '0;
    end else begin
      unique case (state_q)
        PWR_WAIT: begin
          if (cnt_q == CW'(T_PWRON - 1)) begin
            cnt_q   <= '0;
            d_q     <= cur_b_d[3:0];
            rs_q    <= 1'b0;
            state_q <= SETUP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SETUP: begin
          if (cnt_q == CW'(1)) begin
            cnt_q   <= '0;
            e_q     <= 1'b1;
            state_q <= E_HI;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        E_HI: begin
          if (cnt_q == CW'(E_HIGH - 1)) begin
            cnt_q   <= '0;
            e_q     <= 1'b0;
            state_q <= (step_q >= 5'd4 && !lo_q) ? GAP : WAIT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        GAP: begin
          if (cnt_q == CW'(NIB_GAP - 1)) begin
            cnt_q   <= '0;
            lo_q    <= 1'b1;
            d_q     <= cur_b_d[3:0];
            state_q <= SETUP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT: begin
          if (cnt_q == wait_end_d) begin
            cnt_q <= '0;
            lo_q  <= 1'b0;
            if (step_q == 5'd7) begin
              ready_q <= 1'b1;
              force_q <= 1'b1;
              state_q <= IDLE;
            end else if (step_q == 5'd16) begin
              state_q <= IDLE;
            end else begin
              step_q  <= step_q + 5'd1;
              d_q     <= (step_q >= 5'd3) ? nxt_b_d[7:4]
                                          : nxt_b_d[3:0];
              rs_q    <= (step_q >= 5'd8);
              state_q <= SETUP;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        IDLE: begin
          if (force_q ||
              {hrs_digits, min_digits, sec_digits} !=
              {hrs_q, min_q, sec_q})
            state_q <= SNAP;
        end
        SNAP: begin
          // One-cycle capture keeps the rendered frame coherent.
          hrs_q   <= hrs_digits;
          min_q   <= min_digits;
          sec_q   <= sec_digits;
          force_q <= 1'b0;
          step_q  <= 5'd8;
          d_q     <= 4'h8;
          rs_q    <= 1'b0;
          cnt_q   <= '0;
          state_q <= SETUP;
        end
        default: state_q <= PWR_WAIT;
      endcase
    end
  end

  assign SF_D   = d_q;
  assign LCD_E  = e_q;
  assign LCD_RS = rs_q;
  assign LCD_RW = 1'b0;
  assign SF_CE0 = 1'b1;
  assign ready  = ready_q;

endmodule

// File: doc/lcd_time_display.md
Name: lcd_time_display

Overview:
- Consumer end of the watch core's time interface: samples hrs/min/sec binary counters and renders "HH:MM:SS" on the 16x2 character LCD (HD44780-compatible, 4-bit bus, write-only).
- Performs the full power-on LCD init sequence.
- After init, rewrites line 1, columns 0-7, whenever the time value changes.
- Sits beside the watch core in the board top level; drives the LCD pins directly.

Parameters:
- T_PWRON, 750000: cycles of power-on wait before the first nibble (15 ms @ 50 MHz).
- T_INIT1, 205000: wait after 1st init nibble (4.1 ms).
- T_INIT2, 5000: wait after 2nd init nibble (100 us).
- T_CMD, 2000: wait after 3rd/4th init nibbles and after every byte except clear (40 us).
- T_CLEAR, 82000: wait after clear-display byte 0x01 (1.64 ms).
- E_HIGH, 12: LCD_E high time in cycles (240 ns).
- NIB_GAP, 50: cycles from the end of the upper-nibble E pulse to the start of the lower-nibble setup (1 us).

Ports:
- CLK  in  1  system clock
- BTN_SOUTH  in  1  asynchronous, active-high reset
- sec_digits  in  6  seconds, binary
- min_digits  in  6  minutes, binary
- hrs_digits  in  5  hours, binary
- SF_D  out  4  LCD data nibble (board pins SF_D[11:8])
- LCD_E  out  1  LCD enable strobe
- LCD_RS  out  1  0 = command, 1 = data
- LCD_RW  out  1  always 0 (write only)
- SF_CE0  out  1  always 1 (StrataFlash disabled, bus owned by LCD)
- ready  out  1  high once init is complete

Behaviour:
Interface decision:
- One clock, CLK.
- Reset BTN_SOUTH is asynchronous and active-high.

Reset:
- SF_D=0, LCD_E=0, LCD_RS=0, LCD_RW=0, SF_CE0=1, ready=0.
- FSM goes to PWR_WAIT; all counters and snapshot registers cleared.
- Reset asserted at any point aborts immediately; a partially pulsed LCD_E drops at once.
- After release, the full init sequence restarts from PWR_WAIT.

Nibble write primitive:
- Drive RS and SF_D, hold 2 cycles of setup.
- LCD_E high for exactly E_HIGH cycles, then low.
- SF_D and RS held 1 cycle after LCD_E falls.

Byte write:
- Upper nibble, then NIB_GAP cycles, then lower nibble.
- Then T_CMD cycles, or T_CLEAR if the byte is 0x01.

Init FSM (all nibbles/bytes RS=0):
- PWR_WAIT (T_PWRON)
- Nibble 0x3, wait T_INIT1
- Nibble 0x3, wait T_INIT2
- Nibble 0x3, wait T_CMD
- Nibble 0x2, wait T_CMD
- Bytes 0x28, 0x06, 0x0C, 0x01
- ready goes to 1 on the cycle after the T_CLEAR wait ends; enter IDLE with a forced-refresh flag set.

Display FSM:
- IDLE: if the forced flag is set, or the live {hrs,min,sec} differs from the last-written snapshot, go to SNAP next cycle. Otherwise stay; no LCD_E activity.
- SNAP: capture all three inputs in the same cycle (coherent frame); clear the forced flag.
- ADDR: byte 0x80, RS=0.
- WRITE: 8 bytes, RS=1, in this order:
  - '0'+hrs/10, '0'+hrs%10
  - 0x3A
  - '0'+min/10, '0'+min%10
  - 0x3A
  - '0'+sec/10, '0'+sec%10
  - Then return to IDLE.
- Input changes during ADDR/WRITE are ignored until the frame ends. The IDLE compare then catches the latest value; intermediate values may be skipped.
- Out-of-range inputs are not clamped (e.g. sec=63 -> "63"; hrs=31 -> "31"). Tens digit is at most 6.
- LCD busy flag is never read; only fixed waits are used.

Test Plan (bench overrides parameters to small values, e.g. T_PWRON=20, T_INIT1=10, T_CLEAR=15, T_CMD=5, NIB_GAP=3, E_HIGH=2):
1. Reset pulse then release -> SF_CE0=1 and LCD_RW=0 throughout. LCD_E nibble sequence with RS=0 is 3,3,3,2,2,8,0,6,0,C,0,1. ready rises after the final T_CLEAR wait. Each LCD_E pulse is high exactly E_HIGH cycles, and SF_D is stable from setup through 1 cycle after the fall.
2. hrs=13, min=45, sec=7 held through init -> after ready: RS=0 byte 0x80, then RS=1 bytes 31 33 3A 34 35 3A 30 37.
3. Inputs static after the first frame -> no further LCD_E pulses for 1000 cycles.
4. sec changes 7->8 during the 3rd data byte -> that frame completes ending "30 37". The next frame follows, ending "30 38".
5. Inputs 23:59:59 then 00:00:00 -> frames 32 33 3A 35 39 3A 35 39 and 30 30 3A 30 30 3A 30 30.
6. BTN_SOUTH asserted mid-WRITE with LCD_E high -> LCD_E, SF_D, and ready go to 0 asynchronously. After release, the full init sequence repeats before the next frame.
